// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the PC, issues word addresses to a synchronous-read imem, presents instr/pc/opCode to decode.
// Latency: startProcess at edge N -> first valid instruction in cycle N+1; redirect costs one bubble cycle.
// Backpressure: stall holds pc/instr (the presented word is captured in holdReg); redirect overrides stall.
// Ports: clk/rstN (sync, active-low); startProcess/endProcess sequencing; stall; redirect/redirectPC;
//        imemAddr/imemRdata memory side; instr, opCode, pc, pcPlus4, instrValid, misaligned to decode.
// Optional: define IF_FETCH_COUNT_EN to add the fetchCount output (valid, unstalled, non-redirected cycles).
module instruction_fetch #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                startProcess,
  input  logic                endProcess,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirectPC,
  output logic [PC_WIDTH-1:0] imemAddr,
  input  logic [31:0]         imemRdata,
  output logic [31:0]         instr,
  output logic [6:0]          opCode,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pcPlus4,
  output logic                instrValid,
  output logic                misaligned
`ifdef IF_FETCH_COUNT_EN
  ,
  output logic [31:0]         fetchCount
`endif
);

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [PC_WIDTH-1:0] pcF;      // next address to issue
  logic [PC_WIDTH-1:0] pcD;      // address of the word being presented
  logic                validD;
  logic [31:0]         holdReg;
  logic                holding;
  logic                bad_target;

  assign bad_target = redirect && (redirectPC[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (startProcess) next_state = S_FETCH;
      S_FETCH: if (endProcess || bad_target) next_state = S_HALT;
      S_HALT:  next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

  // Fetch datapath
  always_ff @(posedge clk) begin
    if (!rstN) begin
      pcF        <= RESET_PC;
      pcD        <= RESET_PC;
      validD     <= 1'b0;
      holding    <= 1'b0;
      holdReg    <= 32'h0;
      misaligned <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // The start edge issues the first sequential step so RESET_PC is
          // presented (with its memory word) on the very next cycle.
          if (startProcess) begin
            pcD     <= pcF;
            pcF     <= pcF + PC_STEP;
            validD  <= 1'b1;
            holding <= 1'b0;
          end
        end
        S_FETCH: begin
          if (endProcess) begin
            validD <= 1'b0;
          end else if (bad_target) begin
            misaligned <= 1'b1;
            validD     <= 1'b0;
          end else if (redirect) begin
            // Squash the word already in flight; pcD is left as-is since
            // nothing valid is presented until the target arrives.
            pcF     <= redirectPC;
            validD  <= 1'b0;
            holding <= 1'b0;
          end else if (stall) begin
            // Memory keeps reading pcF (the following word), so the
            // presented word must be captured on the first stalled edge.
            if (!holding) begin
              holdReg <= imemRdata;
              holding <= 1'b1;
            end
          end else begin
            pcD     <= pcF;
            pcF     <= pcF + PC_STEP;
            validD  <= 1'b1;
            holding <= 1'b0;
          end
        end
        S_HALT: begin
          validD <= 1'b0;
        end
        default: begin
          validD <= 1'b0;
        end
      endcase
    end
  end

`ifdef IF_FETCH_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rstN) begin
      fetchCount <= 32'h0;
    end else if ((state == S_FETCH) && validD && !stall && !redirect) begin
      fetchCount <= fetchCount + 32'd1;
    end
  end
`endif

  // Outputs
  always_comb begin
    imemAddr   = pcF;
    pc         = pcD;
    pcPlus4    = pcD + PC_STEP;
    instrValid = validD;
    instr      = holding ? holdReg : imemRdata;
    opCode     = instr[6:0];
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        startProcess = 1'b0;
  logic        endProcess = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPC = 32'h0;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata = 32'h0;
  logic [31:0] instr;
  logic [6:0]  opCode;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        instrValid;
  logic        misaligned;
`ifdef IF_FETCH_COUNT_EN
  logic [31:0] fetchCount;
`endif

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  instruction_fetch #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rstN         (rstN),
    .startProcess (startProcess),
    .endProcess   (endProcess),
    .stall        (stall),
    .redirect     (redirect),
    .redirectPC   (redirectPC),
    .imemAddr     (imemAddr),
    .imemRdata    (imemRdata),
    .instr        (instr),
    .opCode       (opCode),
    .pc           (pc),
    .pcPlus4      (pcPlus4),
    .instrValid   (instrValid),
    .misaligned   (misaligned)
`ifdef IF_FETCH_COUNT_EN
    ,
    .fetchCount   (fetchCount)
`endif
  );

  always #5 clk = ~clk;

  // Memory contents: a simple address-derived pattern so each word (and its opcode) differs.
  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  // Synchronous-read instruction memory
  always @(posedge clk) imemRdata <= memword(imemAddr);

  // Reference model: what decode should see, in terms of the instruction stream
  int          m_mode = 0;     // 0 idle, 1 running, 2 halted
  logic [31:0] m_next = 32'h0; // next address the stream continues from
  logic [31:0] m_pc   = 32'h0;
  bit          m_valid = 1'b0;
  bit          m_mis = 1'b0;
  logic [31:0] m_cnt = 32'h0;

  always @(posedge clk) begin
    if (!rstN) begin
      m_mode = 0; m_next = 32'h0; m_pc = 32'h0; m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
    end else if (m_mode == 0) begin
      if (startProcess) begin
        m_mode = 1; m_pc = 32'h0; m_next = 32'h4; m_valid = 1'b1;
      end
    end else if (m_mode == 1) begin
      if (m_valid && !stall && !redirect) m_cnt = m_cnt + 1;
      if (endProcess) begin
        m_mode = 2; m_valid = 1'b0;
      end else if (redirect && redirectPC[1:0] != 2'b00) begin
        m_mode = 2; m_valid = 1'b0; m_mis = 1'b1;
      end else if (redirect) begin
        m_next = redirectPC; m_valid = 1'b0;
      end else if (!stall) begin
        m_pc = m_next; m_next = m_next + 32'h4; m_valid = 1'b1;
      end
    end else begin
      m_valid = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (mon_en) begin
      check("valid", {31'h0, instrValid}, {31'h0, m_valid});
      check("pc", pc, m_pc);
      check("pcPlus4", pcPlus4, m_pc + 32'h4);
      check("imemAddr", imemAddr, m_next);
      check("misaligned", {31'h0, misaligned}, {31'h0, m_mis});
      if (m_valid) begin
        check("instr", instr, memword(m_pc));
        check("opCode", {25'h0, opCode}, {25'h0, memword(m_pc) & 32'h7F});
      end
`ifdef IF_FETCH_COUNT_EN
      check("fetchCount", fetchCount, m_cnt);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    rstN = 1'b0;
    tick(); tick();
    mon_en = 1'b1;
    check("rst_valid", {31'h0, instrValid}, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_pcPlus4", pcPlus4, 32'h4);
    check("rst_imemAddr", imemAddr, 32'h0);

    // Start and sequential fetch
    rstN = 1'b1; startProcess = 1'b1;
    tick();
    startProcess = 1'b0;
    check("start_pc0", pc, 32'h0);
    check("start_valid", {31'h0, instrValid}, 32'h1);
    check("start_instr0", instr, 32'h5A00_0013);
    tick();
    check("seq_pc4", pc, 32'h4);
    tick();
    check("seq_pc8", pc, 32'h8);

    // Stall three cycles at pc = 8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", pc, 32'h8);
      check("stall_instr", instr, 32'h5A00_001B);
    end
    stall = 1'b0;
    tick();
    check("release_pc", pc, 32'hC);
    check("release_instr", instr, 32'h5A00_001F);

    // Redirect to 0x40
    redirect = 1'b1; redirectPC = 32'h40;
    tick();
    redirect = 1'b0;
    check("redir_bubble", {31'h0, instrValid}, 32'h0);
    tick();
    check("redir_pc", pc, 32'h40);
    check("redir_instr", instr, 32'h5A00_0053);

    // Redirect with stall in the same cycle
    redirect = 1'b1; stall = 1'b1; redirectPC = 32'h80;
    tick();
    redirect = 1'b0; stall = 1'b0;
    check("rs_bubble", {31'h0, instrValid}, 32'h0);
    tick();
    check("rs_pc", pc, 32'h80);
    tick();
    check("rs_pc_next", pc, 32'h84);

    // endProcess, start ignored in HALT, reset out of HALT
    endProcess = 1'b1;
    tick();
    endProcess = 1'b0;
    check("end_valid", {31'h0, instrValid}, 32'h0);
    startProcess = 1'b1;
    tick(); tick();
    startProcess = 1'b0;
    check("halt_ignore_start", {31'h0, instrValid}, 32'h0);
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    check("halt_rst_pc", pc, 32'h0);
    check("halt_rst_addr", imemAddr, 32'h0);

    // Misaligned redirect
    startProcess = 1'b1;
    tick();
    startProcess = 1'b0;
    tick();
    redirect = 1'b1; redirectPC = 32'h42;
    tick();
    redirect = 1'b0;
    check("mis_flag", {31'h0, misaligned}, 32'h1);
    startProcess = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mis_valid", {31'h0, instrValid}, 32'h0);
    end
    startProcess = 1'b0;
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    check("mis_cleared", {31'h0, misaligned}, 32'h0);

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      rstN         = ($urandom_range(0, 299) != 0);
      startProcess = ($urandom_range(0, 9) == 0);
      endProcess   = ($urandom_range(0, 199) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      redirect     = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 9))
        0:       redirectPC = {$urandom_range(0, 255), 2'b00} | 32'(($urandom_range(1, 3)));
        1:       redirectPC = 32'hFFFF_FFF0 + {28'h0, 2'(($urandom_range(0, 3))), 2'b00};
        default: redirectPC = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      endcase
      tick();
    end

    rstN = 1'b1; startProcess = 1'b0; endProcess = 1'b0; stall = 1'b0; redirect = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
